// File: rtl/sqrt_request_arbiter.sv
// rtl/sqrt_request_arbiter.sv - round-robin arbiter sharing one fixed-latency square-root unit
// Issues at most one operand per cycle and routes each result back to its requester by tag.
module sqrt_request_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int WIDTH        = 32,
  parameter int LONG_WIDTH   = 64,
  parameter int SCALE        = 17,
  parameter int SQRT_LATENCY = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            request,
  input  logic [NUM_REQ*LONG_WIDTH-1:0] operand,
  output logic [NUM_REQ-1:0]            grant,
  output logic [NUM_REQ-1:0]            result_valid,
  output logic [WIDTH-1:0]              result,
  output logic                          result_error,
  output logic                          result_inexact,
  output logic                          protocol_error,
  output logic                          busy,
  output logic [LONG_WIDTH-1:0]         sqrt_operand,
  output logic                          sqrt_input_ready,
  input  logic                          sqrt_output_ready,
  input  logic [WIDTH-1:0]              sqrt_result
);

  localparam int IDXW  = $clog2(NUM_REQ);
  localparam int DEPTH = SQRT_LATENCY + 1;
  localparam logic [WIDTH-1:0] LUT_SENTINEL = WIDTH'(32'h0FFFFFFF);

  typedef enum logic {IDLE, ISSUE} issue_state_t;

  typedef struct packed {
    logic            valid;
    logic [IDXW-1:0] idx;
    logic            inexact;
    logic            range_err;
  } tag_t;

  issue_state_t          state, next_state;
  logic [IDXW-1:0]       ptr, ptr_next;
  logic [NUM_REQ-1:0]    eligible;
  logic                  win_found;
  logic [IDXW-1:0]       win_idx;
  logic [IDXW:0]         slot_sum;
  logic [IDXW-1:0]       slot;
  logic [LONG_WIDTH-1:0] win_operand;
  tag_t                  win_tag;
  tag_t                  tags [DEPTH];
  tag_t                  tail;
  logic                  fire;
  logic                  in_flight;
  logic                  busy_next;
  logic [NUM_REQ-1:0]    grant_next;
  logic [NUM_REQ-1:0]    result_valid_next;

  // A requester whose grant is still high is masked so a held request is not issued twice.
  always_comb begin
    eligible   = request & ~grant;
    win_found  = 1'b0;
    win_idx    = '0;
    slot_sum   = '0;
    slot       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      slot_sum = {1'b0, ptr} + (IDXW+1)'(k);
      if (slot_sum >= (IDXW+1)'(NUM_REQ)) begin
        slot_sum = slot_sum - (IDXW+1)'(NUM_REQ);
      end
      slot = slot_sum[IDXW-1:0];
      if (!win_found && eligible[slot]) begin
        win_found = 1'b1;
        win_idx   = slot;
      end
    end
    next_state = win_found ? ISSUE : IDLE;
  end

  always_comb begin
    win_operand = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (win_idx == IDXW'(k)) begin
        win_operand = operand[k*LONG_WIDTH +: LONG_WIDTH];
      end
    end
    win_tag.valid     = win_found;
    win_tag.idx       = win_idx;
    win_tag.inexact   = |win_operand[SCALE-1:0];
    win_tag.range_err = |win_operand[LONG_WIDTH-1:WIDTH];
    ptr_next   = (win_idx == IDXW'(NUM_REQ-1)) ? '0 : win_idx + IDXW'(1);
    grant_next = win_found ? (NUM_REQ'(1) << win_idx) : '0;
  end

  // The tail tag lines up with the unit's output strobe; any disagreement is a protocol error.
  always_comb begin
    tail              = tags[DEPTH-1];
    fire              = tail.valid & sqrt_output_ready;
    result_valid_next = fire ? (NUM_REQ'(1) << tail.idx) : '0;
    in_flight         = 1'b0;
    for (int k = 0; k < DEPTH-1; k++) begin
      in_flight = in_flight | tags[k].valid;
    end
    busy_next = win_found | fire | in_flight;
  end

  assign sqrt_input_ready = (state == ISSUE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      ptr            <= '0;
      grant          <= '0;
      sqrt_operand   <= '0;
      result_valid   <= '0;
      result         <= '0;
      result_error   <= 1'b0;
      result_inexact <= 1'b0;
      protocol_error <= 1'b0;
      busy           <= 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
        tags[k] <= '0;
      end
    end else begin
      state <= next_state;
      grant <= grant_next;
      if (win_found) begin
        sqrt_operand <= win_operand;
        ptr          <= ptr_next;
      end
      tags[0] <= win_tag;
      for (int k = 1; k < DEPTH; k++) begin
        tags[k] <= tags[k-1];
      end
      result_valid <= result_valid_next;
      if (fire) begin
        result         <= sqrt_result;
        result_inexact <= tail.inexact;
        result_error   <= tail.range_err | (sqrt_result == LUT_SENTINEL);
      end
      if (sqrt_output_ready != tail.valid) begin
        protocol_error <= 1'b1;
      end
      busy <= busy_next;
    end
  end

endmodule

// File: tb/tb_sqrt_request_arbiter.sv
// tb/tb_sqrt_request_arbiter.sv - table-driven bench for sqrt_request_arbiter
module tb_sqrt_request_arbiter;

  localparam logic [255:0] OPS_A = {64'h100000, 64'h80000, 64'h40000, 64'h20000};
  localparam logic [255:0] OPS_B = {64'h0, 64'h40000, 64'h0, 64'h0};
  localparam logic [255:0] OPS_C = {64'h0, 64'h0, 64'h50000, 64'h0};
  localparam logic [255:0] OPS_D = {64'h1_0000_0000, 64'h0, 64'h0, 64'hC80000};

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   request;
  logic [255:0] operand;
  logic [3:0]   grant;
  logic [3:0]   result_valid;
  logic [31:0]  result;
  logic         result_error;
  logic         result_inexact;
  logic         protocol_error;
  logic         busy;
  logic [63:0]  sqrt_operand;
  logic         sqrt_input_ready;
  logic         sqrt_output_ready;
  logic [31:0]  sqrt_result;

  logic         model_ready;
  logic [31:0]  model_result;
  logic         unit_en;
  logic         force_ready;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sqrt_request_arbiter dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .request           (request),
    .operand           (operand),
    .grant             (grant),
    .result_valid      (result_valid),
    .result            (result),
    .result_error      (result_error),
    .result_inexact    (result_inexact),
    .protocol_error    (protocol_error),
    .busy              (busy),
    .sqrt_operand      (sqrt_operand),
    .sqrt_input_ready  (sqrt_input_ready),
    .sqrt_output_ready (sqrt_output_ready),
    .sqrt_result       (sqrt_result)
  );

  // Stand-in for the square-root LUT unit with one cycle of latency.
  function automatic logic [31:0] lut(input logic [63:0] op);
    case (op)
      64'h20000:  return 32'h20000;
      64'h40000:  return 32'h2d413;
      64'h50000:  return 32'h2d413;
      64'h80000:  return 32'h40000;
      64'h100000: return 32'h5a827;
      64'hC80000: return 32'h0FFFFFFF;
      default:    return 32'h12345;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_ready  <= 1'b0;
      model_result <= 32'h0;
    end else begin
      model_ready  <= sqrt_input_ready & unit_en;
      model_result <= lut(sqrt_operand);
    end
  end

  assign sqrt_output_ready = model_ready | force_ready;
  assign sqrt_result       = model_result;

  typedef struct {
    logic [3:0]   req;
    logic [255:0] ops;
    logic [3:0]   g;
    logic [3:0]   rv;
    logic [31:0]  res;
    logic         err;
    logic         inx;
    logic         bsy;
  } vec_t;

  vec_t tbl [18];

  function automatic vec_t mk(input logic [3:0] req, input logic [255:0] ops, input logic [3:0] g,
                              input logic [3:0] rv, input logic [31:0] res, input logic err,
                              input logic inx, input logic bsy);
    vec_t v;
    v.req = req; v.ops = ops; v.g = g; v.rv = rv;
    v.res = res; v.err = err; v.inx = inx; v.bsy = bsy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " grant"}, 64'(grant), 64'h0);
    chk({tag, " result_valid"}, 64'(result_valid), 64'h0);
    chk({tag, " result"}, 64'(result), 64'h0);
    chk({tag, " error"}, 64'(result_error), 64'h0);
    chk({tag, " inexact"}, 64'(result_inexact), 64'h0);
    chk({tag, " protocol_error"}, 64'(protocol_error), 64'h0);
    chk({tag, " busy"}, 64'(busy), 64'h0);
    chk({tag, " sqrt_operand"}, sqrt_operand, 64'h0);
    chk({tag, " sqrt_input_ready"}, 64'(sqrt_input_ready), 64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] g_hist [8];
    logic [3:0] exp_g;
    int n;

    // row i: inputs during cycle i, expected outputs during cycle i+1
    tbl[0]  = mk(4'b1111, OPS_A, 4'b0001, 4'b0000, 32'h0,        1'b0, 1'b0, 1'b1);
    tbl[1]  = mk(4'b1110, OPS_A, 4'b0010, 4'b0000, 32'h0,        1'b0, 1'b0, 1'b1);
    tbl[2]  = mk(4'b1100, OPS_A, 4'b0100, 4'b0001, 32'h20000,    1'b0, 1'b0, 1'b1);
    tbl[3]  = mk(4'b1000, OPS_A, 4'b1000, 4'b0010, 32'h2d413,    1'b0, 1'b0, 1'b1);
    tbl[4]  = mk(4'b0000, OPS_A, 4'b0000, 4'b0100, 32'h40000,    1'b0, 1'b0, 1'b1);
    tbl[5]  = mk(4'b0000, OPS_A, 4'b0000, 4'b1000, 32'h5a827,    1'b0, 1'b0, 1'b1);
    tbl[6]  = mk(4'b0000, OPS_A, 4'b0000, 4'b0000, 32'h5a827,    1'b0, 1'b0, 1'b0);
    tbl[7]  = mk(4'b0100, OPS_B, 4'b0100, 4'b0000, 32'h5a827,    1'b0, 1'b0, 1'b1);
    tbl[8]  = mk(4'b0000, OPS_B, 4'b0000, 4'b0000, 32'h5a827,    1'b0, 1'b0, 1'b1);
    tbl[9]  = mk(4'b0000, OPS_B, 4'b0000, 4'b0100, 32'h2d413,    1'b0, 1'b0, 1'b1);
    tbl[10] = mk(4'b0010, OPS_C, 4'b0010, 4'b0000, 32'h2d413,    1'b0, 1'b0, 1'b1);
    tbl[11] = mk(4'b0000, OPS_C, 4'b0000, 4'b0000, 32'h2d413,    1'b0, 1'b0, 1'b1);
    tbl[12] = mk(4'b0000, OPS_C, 4'b0000, 4'b0010, 32'h2d413,    1'b0, 1'b1, 1'b1);
    tbl[13] = mk(4'b1001, OPS_D, 4'b1000, 4'b0000, 32'h2d413,    1'b0, 1'b1, 1'b1);
    tbl[14] = mk(4'b0001, OPS_D, 4'b0001, 4'b0000, 32'h2d413,    1'b0, 1'b1, 1'b1);
    tbl[15] = mk(4'b0000, OPS_D, 4'b0000, 4'b1000, 32'h12345,    1'b1, 1'b0, 1'b1);
    tbl[16] = mk(4'b0000, OPS_D, 4'b0000, 4'b0001, 32'h0FFFFFFF, 1'b1, 1'b0, 1'b1);
    tbl[17] = mk(4'b0000, OPS_D, 4'b0000, 4'b0000, 32'h0FFFFFFF, 1'b1, 1'b0, 1'b0);

    rst_n = 1'b0;
    request = 4'b0;
    operand = '0;
    unit_en = 1'b1;
    force_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      request = tbl[i].req;
      operand = tbl[i].ops;
      @(negedge clk);
      chk($sformatf("v%0d grant", i), 64'(grant), 64'(tbl[i].g));
      chk($sformatf("v%0d result_valid", i), 64'(result_valid), 64'(tbl[i].rv));
      chk($sformatf("v%0d result", i), 64'(result), 64'(tbl[i].res));
      chk($sformatf("v%0d error", i), 64'(result_error), 64'(tbl[i].err));
      chk($sformatf("v%0d inexact", i), 64'(result_inexact), 64'(tbl[i].inx));
      chk($sformatf("v%0d busy", i), 64'(busy), 64'(tbl[i].bsy));
      chk($sformatf("v%0d protocol_error", i), 64'(protocol_error), 64'h0);
    end

    // requesters 1 and 3 held: grants alternate, results follow two cycles later
    request = 4'b1010;
    operand = OPS_A;
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      g_hist[t] = grant;
      exp_g = (t % 2 == 0) ? 4'b0010 : 4'b1000;
      chk($sformatf("alt%0d grant", t), 64'(grant), 64'(exp_g));
      if (t > 0) chk($sformatf("alt%0d repeat", t), 64'(grant & g_hist[t-1]), 64'h0);
      if (t > 1) chk($sformatf("alt%0d result_valid", t), 64'(result_valid), 64'(g_hist[t-2]));
    end
    request = 4'b0;
    n = 0;
    while (busy && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("alt drain busy", 64'(busy), 64'h0);
    chk("alt last result", 64'(result), 64'h5a827);

    // reset asserted in cycle 2 after two issues
    request = 4'b1111;
    operand = OPS_A;
    @(negedge clk);
    chk("mid g1", 64'(grant), 64'h1);
    @(negedge clk);
    chk("mid g2", 64'(grant), 64'h2);
    rst_n = 1'b0;
    request = 4'b0;
    #1;
    chk_all_zero("mid reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      chk($sformatf("post reset %0d result_valid", t), 64'(result_valid), 64'h0);
    end
    chk("post reset busy", 64'(busy), 64'h0);
    chk("post reset protocol_error", 64'(protocol_error), 64'h0);

    // unit strobes with nothing in flight
    force_ready = 1'b1;
    @(negedge clk);
    force_ready = 1'b0;
    chk("orphan protocol_error", 64'(protocol_error), 64'h1);
    chk("orphan result_valid", 64'(result_valid), 64'h0);
    repeat (3) @(negedge clk);
    chk("orphan sticky", 64'(protocol_error), 64'h1);
    rst_n = 1'b0;
    #1;
    chk("orphan cleared", 64'(protocol_error), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // issued operand whose result never arrives
    unit_en = 1'b0;
    request = 4'b0001;
    operand = OPS_A;
    @(negedge clk);
    request = 4'b0;
    chk("lost grant", 64'(grant), 64'h1);
    @(negedge clk);
    chk("lost pending", 64'(protocol_error), 64'h0);
    @(negedge clk);
    chk("lost protocol_error", 64'(protocol_error), 64'h1);
    chk("lost result_valid", 64'(result_valid), 64'h0);
    unit_en = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
